// File: rtl/sr_dmem.sv
// Data-memory responder for sr_cpu: combinational loads, byte/half/word stores on posedge.
// Define SR_DMEM_MMIO_EN to decode the GPIO / CYCLE / STATUS window at 0xFFFF_0000.
module sr_dmem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmAddr,
    input  logic [31:0] dmDataW,
    input  logic        dmWe,
    input  logic        w_byte,
    input  logic        w_half,
    input  logic        w_word,
    input  logic        sign,
    output logic [31:0] dmDataR,
    output logic        misalign,
    output logic        stickyErr,
    output logic [31:0] gpioOut
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];
    logic                  sz_b, sz_h, sz_w, sz_any;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  wr_ok, ram_we, is_mmio, mapped;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           word_rd;
    logic                  sticky_q, sticky_d;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic                  unused_addr;

    assign sz_b   = w_byte;
    assign sz_h   = ~w_byte & w_half;
    assign sz_w   = ~w_byte & ~w_half & w_word;
    assign sz_any = w_byte | w_half | w_word;

    assign misalign    = (sz_h & dmAddr[0]) | (sz_w & (dmAddr[1:0] != 2'b00));
    assign wr_ok       = dmWe & ~rst & sz_any & ~misalign;
    assign widx        = dmAddr[ADDR_WIDTH+1:2];
    assign unused_addr = ^dmAddr[31:ADDR_WIDTH+2];

    // Sub-word data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        be    = 4'b0000;
        wdata = dmDataW;
        if (sz_b) begin
            be    = 4'b0001 << dmAddr[1:0];
            wdata = {4{dmDataW[7:0]}};
        end else if (sz_h) begin
            be    = dmAddr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{dmDataW[15:0]}};
        end else if (sz_w) begin
            be    = 4'b1111;
        end
    end

`ifdef SR_DMEM_MMIO_EN
    logic [31:0] gpio_q, gpio_d, cyc_q, cyc_d, mmio_rd;
    logic        mmio_hit, sel_gpio, sel_stat, w1c;

    assign is_mmio  = (dmAddr[31:16] == 16'hFFFF);
    assign sel_gpio = is_mmio & (dmAddr[15:2] == 14'd0);
    assign sel_stat = is_mmio & (dmAddr[15:2] == 14'd2);
    assign w1c      = wr_ok & sel_stat & be[0] & wdata[0];
    assign cyc_d    = cyc_q + 32'd1;
    assign sticky_d = misalign | (sticky_q & ~w1c);
    assign word_rd  = is_mmio ? mmio_rd : mem_q[widx];
    assign mapped   = ~is_mmio | mmio_hit;
    assign gpioOut  = gpio_q;

    always_comb begin
        mmio_hit = 1'b1;
        mmio_rd  = '0;
        case (dmAddr[15:2])
            14'd0:   mmio_rd = gpio_q;
            14'd1:   mmio_rd = cyc_q;
            14'd2:   mmio_rd = {31'b0, sticky_q};
            default: mmio_hit = 1'b0;
        endcase
    end

    always_comb begin
        gpio_d = gpio_q;
        for (int i = 0; i < 4; i++)
            if (wr_ok & sel_gpio & be[i]) gpio_d[8*i +: 8] = wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q <= '0;
            cyc_q  <= '0;
        end else begin
            gpio_q <= gpio_d;
            cyc_q  <= cyc_d;
        end
    end
`else
    assign is_mmio  = 1'b0;
    assign mapped   = 1'b1;
    assign word_rd  = mem_q[widx];
    assign sticky_d = sticky_q | misalign;
    assign gpioOut  = '0;
`endif

    assign ram_we = wr_ok & ~is_mmio;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we & be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end
    assign stickyErr = sticky_q;

    assign lane_b = word_rd[{dmAddr[1:0], 3'b000} +: 8];
    assign lane_h = dmAddr[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        dmDataR = '0;
        if (sz_any & ~misalign & mapped) begin
            if (sz_b)      dmDataR = {{24{sign & lane_b[7]}}, lane_b};
            else if (sz_h) dmDataR = {{16{sign & lane_h[15]}}, lane_h};
            else           dmDataR = word_rd;
        end
    end
endmodule

// File: doc/sr_dmem.md
# sr_dmem

Data-memory responder for `sr_cpu`: the slave end of the CPU's data-memory port (`dmAddr`, `dmDataW`, `dmWe`, `w_byte`/`w_half`/`w_word`, `sign`, `dmDataR`).
- Serves single-cycle loads combinationally.
- Commits byte/half/word stores on the clock edge.
- Flags misaligned accesses.
- Optionally decodes a small memory-mapped I/O window: GPIO output register, free-running cycle counter, sticky error status.

## Interface
- `ADDR_WIDTH`, 10, word-address bits of the RAM array (2^ADDR_WIDTH 32-bit words).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `dmAddr`  in  32  byte address.
- `dmDataW`  in  32  store data; sub-word data is right-aligned.
- `dmWe`  in  1  store strobe for the current cycle.
- `w_byte`, `w_half`, `w_word`  in  1 each  access size. Priority byte > half > word; none asserted = no access.
- `sign`  in  1  sign-extend sub-word loads (1) or zero-extend (0).
- `dmDataR`  out  32  load data, combinational.
- `misalign`  out  1  combinational: current access is misaligned.
- `stickyErr`  out  1  registered: a misaligned access has occurred since last clear.
- `gpioOut`  out  32  GPIO output register.

## Operation
- **Region decode.**
  - MMIO when `SR_DMEM_MMIO_EN` is defined and `dmAddr[31:16]==16'hFFFF`.
  - RAM otherwise; word index `dmAddr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so the RAM aliases.
- **Alignment.**
  - Half is misaligned when `dmAddr[0]=1`.
  - Word is misaligned when `dmAddr[1:0]!=0`.
  - Byte is never misaligned.
  - `misalign` = size valid & misaligned, independent of `dmWe`.
- **Loads.**
  - The selected word W is the RAM word or the MMIO register.
  - Byte: lane `dmAddr[1:0]`, i.e. W[8*a+7:8*a].
  - Half: lane `dmAddr[1]`.
  - Sub-word results are extended per `sign`.
  - `dmDataR=0` when there is no access, the access is misaligned, or the MMIO address is unmapped.
- **Stores**, at posedge when `dmWe & !rst & size valid & !misalign`:
  - byte writes lane `dmAddr[1:0]` with `dmDataW[7:0]`;
  - half writes lane `dmAddr[1]` with `dmDataW[15:0]`;
  - word writes all four lanes;
  - the other lanes are preserved. A misaligned store is dropped.
- **MMIO map** (byte offsets within 0xFFFF_0000):
  - 0x0 GPIO: RW with byte-lane writes.
  - 0x4 CYCLE: RO; writes ignored.
  - 0x8 STATUS: bit0 = stickyErr, other bits read 0. A store with `dmDataW[0]=1` to lane 0 clears it (W1C).
  - Other offsets read 0; writes are ignored.
- **stickyErr.**
  - Set at posedge when `misalign` is 1.
  - Set wins over a simultaneous W1C clear.
- **CYCLE counter.**
  - Increments by 1 every non-reset cycle.
  - Wraps 0xFFFF_FFFF -> 0.

## Timing
- Load latency 0: `dmDataR` and `misalign` are combinational from the inputs and current state.
- A store is visible to loads from the cycle after its posedge.
- Read-during-write to the same address returns the old data.
- Reset values:
  - `gpioOut=0`, CYCLE=0, `stickyErr=0`.
  - RAM is not initialised; contents are undefined until written.
  - `dmDataR` and `misalign` follow the inputs even during reset.
- Reset mid-operation:
  - a store presented in a cycle with `rst=1` is dropped;
  - CYCLE holds 0 while `rst=1`.
  - The first cycle after deassertion reads CYCLE=0, the next reads 1.
- No handshake and no stall: every access completes in the cycle it is presented, as the single-cycle CPU requires.

## Configuration
- `SR_DMEM_MMIO_EN` defined:
  - MMIO window decoded as above;
  - GPIO, CYCLE and STATUS registers present.
- Undefined:
  - no MMIO decode; all addresses alias into RAM;
  - `gpioOut` tied to 0; no counter logic;
  - `stickyErr` still sets on misalignment but clears only on `rst`.

## Test plan
- **Byte/half stores, sign-extended loads.** Word store 0x1122_3344 @0x10; byte store 0xAB @0x11; half store 0x8001 @0x12.
  - Word load @0x10 -> 0x8001_AB44.
  - Signed byte load @0x11 -> 0xFFFF_FFAB; unsigned -> 0x0000_00AB.
  - Signed half load @0x12 -> 0xFFFF_8001.
- **Misaligned store.** Word store 0xDEAD_BEEF @0x22 with 0x0 pre-stored at 0x20.
  - Same cycle: `misalign=1`.
  - Next cycle: `stickyErr=1`, and word load @0x20 -> 0x0.
- **Read-during-write.** Word 5 stored @0x40, then store 7 @0x40.
  - Load in the store cycle -> 5; next cycle -> 7.
- **MMIO** (`SR_DMEM_MMIO_EN`).
  - Byte store 0x5A @0xFFFF_0001 -> `gpioOut=0x0000_5A00`.
  - CYCLE read in the k-th cycle after reset release -> k-1.
  - Store 1 @0xFFFF_0008 clears `stickyErr`.
  - A simultaneous misaligned access and clear leaves `stickyErr=1`.
- **Reset mid-operation.** Assert `rst` with a word store pending @0x0 and `gpioOut=0xFFFF_FFFF`.
  - Store is dropped; after reset `gpioOut=0`, `stickyErr=0`, CYCLE=0.
- **No-size access.** All size bits 0 with `dmWe=1`.
  - `dmDataR=0`, `misalign=0`, no RAM change.
